// File: rtl/arf_err_stat.sv
// rtl/arf_err_stat.sv - var-vs-acc filter error statistics: signed error sums and peak |error| per run
// Optional squared-error sums are built when ARF_SQERR_EN is defined.
module arf_err_stat #(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             out_27_var,
    input  logic [63:0]             out_27_acc,
    input  logic [63:0]             out_28_var,
    input  logic [63:0]             out_28_acc,
    output logic signed [ACC_W-1:0] sum_err_27,
    output logic signed [ACC_W-1:0] sum_err_28,
    output logic [64:0]             max_abs_27,
    output logic [64:0]             max_abs_28,
    output logic [15:0]             sample_cnt,
    output logic                    busy,
    output logic                    done
`ifdef ARF_SQERR_EN
    ,
    output logic [79:0]             sq_err_27,
    output logic [79:0]             sq_err_28
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(N_SAMPLES - 1);

    state_t             state_q;
    logic               drain_q;
    logic               in_ready_q, busy_q, done_q;
    logic [15:0]        cnt_q;
    logic               v1_q;
    logic [64:0]        diff27_q, diff28_q;
    logic [64:0]        diff27_d, diff28_d;
    logic [64:0]        abs27_d, abs28_d;
    logic [ACC_W-1:0]   sum27_q, sum28_q, sum27_d, sum28_d;
    logic [64:0]        max27_q, max28_q;
    logic               accept, last_accept, start_go;

    assign accept      = in_valid && in_ready_q;
    assign last_accept = accept && (cnt_q == LAST_CNT);
    assign start_go    = start && (state_q == S_IDLE || state_q == S_DONE);

    // Sign-extend before subtracting so the full 65-bit difference is exact.
    assign diff27_d = {out_27_var[63], out_27_var} - {out_27_acc[63], out_27_acc};
    assign diff28_d = {out_28_var[63], out_28_var} - {out_28_acc[63], out_28_acc};
    assign abs27_d  = diff27_q[64] ? (~diff27_q + 65'd1) : diff27_q;
    assign abs28_d  = diff28_q[64] ? (~diff28_q + 65'd1) : diff28_q;
    assign sum27_d  = sum27_q + {{(ACC_W-65){diff27_q[64]}}, diff27_q};
    assign sum28_d  = sum28_q + {{(ACC_W-65){diff28_q[64]}}, diff28_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            drain_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) begin
                    state_q    <= S_ACC;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                end
                S_ACC: if (last_accept) begin
                    state_q    <= S_DRAIN;
                    in_ready_q <= 1'b0;
                    drain_q    <= 1'b0;
                end
                S_DRAIN: begin
                    // Two drain cycles let the last sample clear both pipeline stages.
                    if (drain_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            v1_q     <= 1'b0;
            diff27_q <= '0;
            diff28_q <= '0;
            sum27_q  <= '0;
            sum28_q  <= '0;
            max27_q  <= '0;
            max28_q  <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                diff27_q <= diff27_d;
                diff28_q <= diff28_d;
            end
            if (start_go) begin
                cnt_q   <= '0;
                sum27_q <= '0;
                sum28_q <= '0;
                max27_q <= '0;
                max28_q <= '0;
            end else begin
                if (accept) cnt_q <= cnt_q + 16'd1;
                if (v1_q) begin
                    sum27_q <= sum27_d;
                    sum28_q <= sum28_d;
                    if (abs27_d > max27_q) max27_q <= abs27_d;
                    if (abs28_d > max28_q) max28_q <= abs28_d;
                end
            end
        end
    end

`ifdef ARF_SQERR_EN
    logic [79:0] sq27_q, sq28_q;

    function automatic logic [63:0] sq_sat(input logic [64:0] d);
        logic [31:0] mag;
        if (!d[64] && d[63:31] != '0)     mag = 32'h7FFF_FFFF;
        else if (d[64] && d[63:31] != '1) mag = 32'h8000_0000;
        else if (d[64])                   mag = ~d[31:0] + 32'd1;
        else                              mag = d[31:0];
        return {32'b0, mag} * {32'b0, mag};
    endfunction

    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            sq27_q <= '0;
            sq28_q <= '0;
        end else if (v1_q) begin
            sq27_q <= sq27_q + {16'b0, sq_sat(diff27_q)};
            sq28_q <= sq28_q + {16'b0, sq_sat(diff28_q)};
        end
    end

    assign sq_err_27 = sq27_q;
    assign sq_err_28 = sq28_q;
`endif

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = cnt_q;
    assign sum_err_27 = sum27_q;
    assign sum_err_28 = sum28_q;
    assign max_abs_27 = max27_q;
    assign max_abs_28 = max28_q;
endmodule

// File: doc/arf_err_stat.md
ARF_ERR_STAT -- requirements
Module: arf_err_stat

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 256, the number of accepted samples per measurement run (1..65535).
REQ-002 SHALL have parameter ACC_W, default 80, the width of the signed error-sum accumulators.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1; a one-cycle pulse begins a run.
REQ-006 SHALL have port in_valid, input, 1; the sample inputs are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1; high only in ACC.
REQ-008 SHALL have ports out_27_var, out_27_acc, out_28_var and out_28_acc, input, 64 each; these are the variance-model and accurate-model filter outputs, two's complement.
REQ-009 SHALL have ports sum_err_27 and sum_err_28, output, ACC_W each, signed running sums of (var - acc).
REQ-010 SHALL have ports max_abs_27 and max_abs_28, output, 65 each, unsigned maximum |var - acc|.
REQ-011 SHALL have port sample_cnt, output, 16, the number of samples accepted in the current run.
REQ-012 SHALL have ports busy and done, output, 1 each.

Function
REQ-013 SHALL implement FSM IDLE -> ACC -> DRAIN -> DONE, with the following transitions:
- IDLE to ACC on start.
- ACC to DRAIN when the N_SAMPLES-th sample is accepted.
- DRAIN to DONE after 2 cycles.
- DONE to ACC on start.
REQ-014 SHALL accept a sample only when in_valid && in_ready; in_valid in IDLE, DRAIN or DONE is ignored.
REQ-015 SHALL, on entry to ACC, clear the sums, maxima and sample_cnt in the same cycle that start is registered.
REQ-016 SHALL compute stage 1 as registered 65-bit diffs, with each input sign-extended to 65 bits before subtraction, so there is no wrap.
REQ-017 SHALL compute stage 2 as the accumulate step: sums add the sign-extended diff modulo 2^ACC_W, and each maximum updates when |diff| > current max.
REQ-018 SHALL make the outputs reflect an accepted sample exactly 2 cycles after acceptance.
REQ-019 SHALL compute |diff| as a 65-bit unsigned value; |-(2^64)| = 2^64 is exact.
REQ-020 SHALL increment sample_cnt at acceptance, giving 1-cycle visibility.
REQ-021 SHALL hold busy high in ACC and DRAIN, and low otherwise.
REQ-022 SHALL hold done high in DONE and clear it on the cycle after start is accepted.
REQ-023 SHALL ignore start in ACC or DRAIN, so a run is never restarted mid-measurement.
REQ-024 SHALL treat start and in_valid in the same cycle in IDLE or DONE as a start only; that sample is not accepted.
REQ-025 SHALL hold all results stable in DONE until the next start.

Reset
REQ-026 SHALL, on rst high at a clock edge, go to IDLE with the following reset values:
- in_ready=0, busy=0, done=0.
- sample_cnt=0.
- sum_err_*=0, max_abs_*=0.
- both pipeline stage-valid flags cleared.
REQ-027 SHALL apply rst mid-run by aborting and discarding the run and any in-flight samples; no partial done is produced.

Configuration
REQ-028 SHALL, with macro ARF_SQERR_EN defined, add outputs sq_err_27 and sq_err_28, 80 bits each, unsigned sums of the squares of the diffs saturated to the signed 32-bit range [-2^31, 2^31-1], wrapping modulo 2^80 and cleared by reset and start, with the same latency as REQ-018.
REQ-029 SHALL, with ARF_SQERR_EN undefined, have no such ports or logic and leave all other behaviour identical.

Verification
REQ-030 SHALL cover this scenario: N_SAMPLES=4, start, then 4 samples with out_27_var=100, out_27_acc=97 -> sum_err_27=12, max_abs_27=3, sample_cnt=4, done high 3 cycles after the last accept.
REQ-031 SHALL cover this scenario: one sample with out_28_var=64'h8000_0000_0000_0000, out_28_acc=64'h7FFF_FFFF_FFFF_FFFF -> diff=-(2^64)+1 with no wrap, max_abs_28=2^64-1, sum_err_28=-(2^64)+1.
REQ-032 SHALL cover this scenario: in_valid held high during IDLE for 10 cycles, then start -> sample_cnt=0 at start, and the first accept occurs on the cycle after start.
REQ-033 SHALL cover this scenario: rst asserted after 2 of 4 samples -> next cycle all outputs are 0 and the state is IDLE; a new start plus 4 samples gives results for those 4 only.
REQ-034 SHALL cover this scenario: start pulsed in ACC after sample 1 -> ignored, and the run completes after 4 samples with unchanged totals.
REQ-035 SHALL cover this scenario with ARF_SQERR_EN defined: diffs of -3, 5 and 2^40 -> sq_err = 9 + 25 + (2^31-1)^2.
